// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - round-robin front end sharing one unsigned 32/16 divider core
// Handles signed operands, divide-by-zero and overflow bypass, and tags results with the requester id.
module div_share_ctrl #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*16-1:0] req_b,
    input  logic [NREQ-1:0]   req_signed,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_q,
    output logic [15:0]       rsp_r,
    output logic              rsp_dz,
    output logic              rsp_ovf,
    output logic              div_start,
    output logic [31:0]       div_a,
    output logic [15:0]       div_b,
    input  logic [31:0]       div_q,
    input  logic [15:0]       div_r,
    input  logic              div_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cur_id;
    logic           q_neg;
    logic           r_neg;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [31:0]    sel_a;
    logic [15:0]    sel_b;
    logic           sel_s;
    logic           accept;
    logic           a_neg;
    logic           b_neg;
    logic [31:0]    mag_a;
    logic [15:0]    mag_b;
    logic           is_dz;
    logic           is_ovf;
    logic [IDW-1:0] ptr_next;

    // Search starts at ptr and wraps, so the most recently served requester is visited last.
    always_comb begin : arb
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_s     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
                sel_a     = req_a[idx*32 +: 32];
                sel_b     = req_b[idx*16 +: 16];
                sel_s     = req_signed[idx];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign accept    = (state == S_IDLE) && gnt_found;
    assign a_neg     = sel_s & sel_a[31];
    assign b_neg     = sel_s & sel_b[15];
    // Negating the most negative value wraps onto itself, which is the correct unsigned magnitude.
    assign mag_a     = a_neg ? (~sel_a + 32'd1) : sel_a;
    assign mag_b     = b_neg ? (~sel_b + 16'd1) : sel_b;
    assign is_dz     = (sel_b == 16'd0);
    assign is_ovf    = sel_s && (sel_a == 32'h8000_0000) && (sel_b == 16'hFFFF);
    assign ptr_next  = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    assign div_start = (state == S_START);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cur_id    <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_dz    <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ptr    <= ptr_next;
                        cur_id <= gnt_idx;
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        div_a  <= mag_a;
                        div_b  <= mag_b;
                        if (is_dz) begin
                            rsp_q     <= 32'hFFFF_FFFF;
                            rsp_r     <= sel_a[15:0];
                            rsp_dz    <= 1'b1;
                            rsp_ovf   <= 1'b0;
                            rsp_id    <= gnt_idx;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else if (is_ovf) begin
                            rsp_q     <= 32'h8000_0000;
                            rsp_r     <= 16'd0;
                            rsp_dz    <= 1'b0;
                            rsp_ovf   <= 1'b1;
                            rsp_id    <= gnt_idx;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            state <= S_START;
                        end
                    end
                end
                // div_ready may still be high from the previous op here; the core drops it on the start edge.
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_ready) begin
                        rsp_q     <= q_neg ? (~div_q + 32'd1) : div_q;
                        rsp_r     <= r_neg ? (~div_r + 16'd1) : div_r;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_dz    <= 1'b0;
                        rsp_ovf   <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb/tb_div_share_ctrl.sv - scoreboard bench for div_share_ctrl with a behavioural 32-cycle divider core
module tb_div_share_ctrl;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              clrn = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic [NREQ-1:0]   req_signed;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_q;
    logic [15:0]       rsp_r;
    logic              rsp_dz;
    logic              rsp_ovf;
    logic              div_start;
    logic [31:0]       div_a;
    logic [15:0]       div_b;
    logic [31:0]       div_q;
    logic [15:0]       div_r;
    logic              div_ready;

    always #5 clk = ~clk;

    div_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .clrn(clrn),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_q(rsp_q),
        .rsp_r(rsp_r), .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .div_ready(div_ready)
    );

    // Divider core: start seen at edge E1, 32 iterations, ready level after edge E33.
    int          core_cnt;
    logic [31:0] core_a;
    logic [15:0] core_b;
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            core_cnt  <= 0;
            div_ready <= 1'b0;
            div_q     <= '0;
            div_r     <= '0;
            core_a    <= '0;
            core_b    <= '0;
        end else if (div_start) begin
            core_cnt  <= 32;
            div_ready <= 1'b0;
            core_a    <= div_a;
            core_b    <= div_b;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                div_ready <= 1'b1;
                div_q     <= core_a / {16'd0, core_b};
                div_r     <= 16'(core_a % {16'd0, core_b});
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ovf;
        int          lat;
        logic [31:0] ma;
        logic [15:0] mb;
        int          acc;
    } item_t;

    item_t sb[$];
    int    acc_ids[$];
    int    acc_count = 0;
    int    n_chk = 0;
    int    n_fail = 0;

    logic [31:0] v_q [NREQ];
    logic [15:0] v_r [NREQ];
    logic        v_dz [NREQ];
    logic        v_ovf [NREQ];
    logic [31:0] v_ma [NREQ];
    logic [15:0] v_mb [NREQ];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Stimulus side: capture each accept and push the expected response for that requester.
    initial begin
        forever begin
            @(negedge clk);
            if (clrn) begin
                if (|req_ready) begin
                    chk("busy_no_accept", sb.size(), 0);
                    chk("ready_while_busy", {31'd0, rsp_valid | div_start}, 0);
                    chk("req_ready_onehot", $countones(req_ready), 1);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        item_t it;
                        it.id  = i;
                        it.q   = v_q[i];
                        it.r   = v_r[i];
                        it.dz  = v_dz[i];
                        it.ovf = v_ovf[i];
                        it.lat = (v_dz[i] || v_ovf[i]) ? 0 : 34;
                        it.ma  = v_ma[i];
                        it.mb  = v_mb[i];
                        it.acc = cyc + 1;
                        sb.push_back(it);
                        acc_ids.push_back(i);
                        acc_count++;
                    end
                end
            end
        end
    end

    // Monitor: checks core launches, response stability and pops the scoreboard on each handshake.
    logic           was_valid = 1'b0;
    logic           prev_start = 1'b0;
    int             starts = 0;
    int             rise = 0;
    logic [31:0]    s_q;
    logic [15:0]    s_r;
    logic [IDW-1:0] s_id;
    logic           s_dz;
    logic           s_ovf;
    initial begin
        forever begin
            @(negedge clk);
            if (!clrn) begin
                was_valid  = 1'b0;
                prev_start = 1'b0;
                starts     = 0;
            end else begin
                if (div_start) begin
                    chk("div_start_width", {31'd0, prev_start}, 0);
                    starts++;
                    if (sb.size() > 0) begin
                        chk("div_a", div_a, sb[0].ma);
                        chk("div_b", {16'd0, div_b}, {16'd0, sb[0].mb});
                    end else begin
                        chk("start_without_request", sb.size(), 1);
                    end
                end
                prev_start = div_start;
                if (rsp_valid) begin
                    if (!was_valid) begin
                        rise  = cyc;
                        s_q   = rsp_q;
                        s_r   = rsp_r;
                        s_id  = rsp_id;
                        s_dz  = rsp_dz;
                        s_ovf = rsp_ovf;
                    end else begin
                        chk("stable_q", rsp_q, s_q);
                        chk("stable_r", {16'd0, rsp_r}, {16'd0, s_r});
                        chk("stable_id", {30'd0, rsp_id}, {30'd0, s_id});
                        chk("stable_flags", {30'd0, rsp_dz, rsp_ovf}, {30'd0, s_dz, s_ovf});
                    end
                    if (rsp_ready) begin
                        if (sb.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_response: got id %0d q %h, expected none", rsp_id, rsp_q);
                        end else begin
                            item_t e;
                            e = sb.pop_front();
                            chk("rsp_id", {30'd0, rsp_id}, e.id);
                            chk("rsp_q", rsp_q, e.q);
                            chk("rsp_r", {16'd0, rsp_r}, {16'd0, e.r});
                            chk("rsp_dz", {31'd0, rsp_dz}, {31'd0, e.dz});
                            chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, e.ovf});
                            chk("latency", rise - e.acc, e.lat);
                            chk("start_count", starts, (e.lat == 34) ? 1 : 0);
                        end
                        starts    = 0;
                        was_valid = 1'b0;
                    end else begin
                        was_valid = 1'b1;
                    end
                end else begin
                    was_valid = 1'b0;
                end
            end
        end
    end

    task automatic drive(input int id, input logic [31:0] a, input logic [15:0] b, input logic s,
                         input logic [31:0] q, input logic [15:0] r, input logic dz, input logic ovf,
                         input logic [31:0] ma, input logic [15:0] mb);
        req_a[id*32 +: 32] = a;
        req_b[id*16 +: 16] = b;
        req_signed[id]     = s;
        v_q[id]   = q;
        v_r[id]   = r;
        v_dz[id]  = dz;
        v_ovf[id] = ovf;
        v_ma[id]  = ma;
        v_mb[id]  = mb;
        req_valid[id] = 1'b1;
    endtask

    task automatic wait_acc(input int id, input int base);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (acc_count > base) break;
        end
        req_valid[id] = 1'b0;
        if (acc_count > base) begin
            chk("accept_id", acc_ids[acc_ids.size()-1], id);
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept for requester %0d, expected one", id);
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !rsp_valid) break;
        end
        if (sb.size() != 0 || rsp_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, {28'd0, req_ready}, 0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 0);
        chk({tag, "_div_start"}, {31'd0, div_start}, 0);
        chk({tag, "_div_a"}, div_a, 0);
        chk({tag, "_div_b"}, {16'd0, div_b}, 0);
        chk({tag, "_rsp_q"}, rsp_q, 0);
        chk({tag, "_rsp_r"}, {16'd0, rsp_r}, 0);
        chk({tag, "_rsp_id_flags"}, {28'd0, rsp_id, rsp_dz, rsp_ovf}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_signed = '0;
        rsp_ready  = 1'b1;
        clrn       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        clrn = 1'b1;
        @(posedge clk);
        #1;

        // Directed single requests; ptr ends at 0 after requester 3.
        base = acc_count;
        drive(0, 32'd100, 16'd7, 1'b1, 32'd14, 16'd2, 1'b0, 1'b0, 32'd100, 16'd7);
        wait_acc(0, base);
        wait_drain(100);
        base = acc_count;
        drive(0, 32'hFFFF_FF9C, 16'd7, 1'b1, 32'hFFFF_FFF2, 16'hFFFE, 1'b0, 1'b0, 32'd100, 16'd7);
        wait_acc(0, base);
        wait_drain(100);
        base = acc_count;
        drive(0, 32'hFFFF_FF9C, 16'hFFF9, 1'b1, 32'd14, 16'hFFFE, 1'b0, 1'b0, 32'd100, 16'd7);
        wait_acc(0, base);
        wait_drain(100);
        base = acc_count;
        drive(2, 32'h1234_5678, 16'd0, 1'b0, 32'hFFFF_FFFF, 16'h5678, 1'b1, 1'b0, 32'd0, 16'd0);
        wait_acc(2, base);
        wait_drain(100);
        base = acc_count;
        drive(1, 32'h8000_0000, 16'hFFFF, 1'b1, 32'h8000_0000, 16'd0, 1'b0, 1'b1, 32'd0, 16'd0);
        wait_acc(1, base);
        wait_drain(100);
        base = acc_count;
        drive(3, 32'hFFFF_FFFF, 16'hFFFF, 1'b0, 32'h0001_0001, 16'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 16'hFFFF);
        wait_acc(3, base);
        wait_drain(100);

        // All requesters held valid: round-robin order 0,1,2,3,0.
        base = acc_count;
        drive(0, 32'd1000, 16'd10, 1'b0, 32'd100, 16'd0, 1'b0, 1'b0, 32'd1000, 16'd10);
        drive(1, 32'd12345, 16'd100, 1'b0, 32'd123, 16'd45, 1'b0, 1'b0, 32'd12345, 16'd100);
        drive(2, 32'hFFFF_FFCE, 16'd3, 1'b1, 32'hFFFF_FFF0, 16'hFFFE, 1'b0, 1'b0, 32'd50, 16'd3);
        drive(3, 32'd65536, 16'd3, 1'b0, 32'h0000_5555, 16'd1, 1'b0, 1'b0, 32'd65536, 16'd3);
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (acc_count >= base + 5) break;
        end
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            if (base + k < acc_ids.size()) chk("rr_order", acc_ids[base+k], k % 4);
            else chk("rr_accept_count", acc_ids.size(), base + 5);
        end
        wait_drain(100);

        // Consumer stall: response held, pending requester 2 not accepted until handshake.
        rsp_ready = 1'b0;
        base = acc_count;
        drive(0, 32'd100, 16'd7, 1'b1, 32'd14, 16'd2, 1'b0, 1'b0, 32'd100, 16'd7);
        wait_acc(0, base);
        for (int k = 0; k < 60; k++) begin
            if (rsp_valid) break;
            @(posedge clk);
            #1;
        end
        chk("stall_rsp_valid", {31'd0, rsp_valid}, 1);
        base = acc_count;
        drive(2, 32'd1000, 16'd10, 1'b0, 32'd100, 16'd0, 1'b0, 1'b0, 32'd1000, 16'd10);
        repeat (10) @(posedge clk);
        #1;
        chk("stall_no_accept", acc_count, base);
        chk("stall_rsp_held", {31'd0, rsp_valid}, 1);
        rsp_ready = 1'b1;
        wait_acc(2, base);
        wait_drain(100);

        // Reset during WAIT drops the in-flight op.
        base = acc_count;
        drive(0, 32'd100, 16'd7, 1'b1, 32'd14, 16'd2, 1'b0, 1'b0, 32'd100, 16'd7);
        wait_acc(0, base);
        repeat (10) @(posedge clk);
        #1;
        clrn = 1'b0;
        sb.delete();
        #1;
        check_reset("midreset");
        repeat (3) @(posedge clk);
        #1;
        clrn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", {31'd0, rsp_valid}, 0);
        base = acc_count;
        drive(1, 32'd100, 16'd7, 1'b1, 32'd14, 16'd2, 1'b0, 1'b0, 32'd100, 16'd7);
        wait_acc(1, base);
        wait_drain(100);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
